// File: rtl/rotor_sincos_cordic.sv
// Sign-magnitude sin/cos of a rotor angle: 2*pi range reduction, quadrant fold, then circular CORDIC.
// Define SINCOS_SAT_EN to clamp output magnitudes to 1.0; by default raw CORDIC magnitudes are output.
module rotor_sincos_cordic #(
    parameter int N    = 24,
    parameter int Q    = 12,
    parameter int ITER = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] Qr,
    output logic [N-1:0] SinQ,
    output logic [N-1:0] CosQ,
    output logic         busy,
    output logic         valid
);

    localparam int G  = 4;
    localparam int W  = N + 2 + G;
    localparam int AW = N + 1;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam int PI_I      = $rtoi(3.14159265358979 * (2.0 ** Q) + 0.5);
    localparam int HALF_PI_I = $rtoi(1.57079632679490 * (2.0 ** Q) + 0.5);
    localparam int TWO_PI_I  = $rtoi(6.28318530717959 * (2.0 ** Q) + 0.5);
    localparam int K_I       = $rtoi(0.60725293500888 * (2.0 ** Q) + 0.5);
`ifdef SINCOS_SAT_EN
    localparam int ONE_I     = 1 << Q;
`endif

    localparam logic signed [AW-1:0] PI_A      = AW'(PI_I);
    localparam logic signed [AW-1:0] HALF_PI_A = AW'(HALF_PI_I);
    localparam logic signed [AW-1:0] TWO_PI_A  = AW'(TWO_PI_I);
    localparam logic signed [W-1:0]  X0        = W'(K_I) <<< G;
    localparam logic signed [W-1:0]  ROUND_W   = W'(1) <<< (G - 1);
    localparam logic [CW-1:0]        LAST_IT   = CW'(ITER - 1);

    typedef enum logic [2:0] {IDLE, REDUCE, FOLD, ROTATE, DONE} state_t;

    state_t               state;
    logic signed [AW-1:0] ang;
    logic signed [AW-1:0] ang_in;
    logic signed [AW-1:0] abs_ang;
    logic signed [AW-1:0] fold_mag;
    logic signed [AW-1:0] folded;
    logic signed [W-1:0]  x;
    logic signed [W-1:0]  y;
    logic signed [W-1:0]  z;
    logic signed [W-1:0]  x_sh;
    logic signed [W-1:0]  y_sh;
    logic signed [W-1:0]  x_nx;
    logic signed [W-1:0]  y_nx;
    logic signed [W-1:0]  z_nx;
    logic [CW-1:0]        cnt;
    logic                 neg_cos;
    logic signed [W-1:0]  atan_tab [ITER];

    // arctan(2^-i) in the datapath's Q+G fractional format, fixed at elaboration
    for (genvar g = 0; g < ITER; g++) begin : g_atan
        localparam int A_I = $rtoi($atan(2.0 ** (-g)) * (2.0 ** (Q + G)) + 0.5);
        assign atan_tab[g] = W'(A_I);
    end

    // Round the Q+G datapath value back to Q and pack as sign-magnitude with no negative zero
    function automatic logic [N-1:0] to_sm(input logic signed [W-1:0] v);
        logic signed [W-1:0] r;
        logic [N-2:0]        mag;
        r   = (v + ROUND_W) >>> G;
        mag = (N-1)'(r[W-1] ? -r : r);
`ifdef SINCOS_SAT_EN
        if (mag > (N-1)'(ONE_I)) mag = (N-1)'(ONE_I);
`endif
        return {r[W-1] && (mag != '0), mag};
    endfunction

    always_comb begin
        ang_in   = Qr[N-1] ? -AW'({1'b0, Qr[N-2:0]}) : AW'({1'b0, Qr[N-2:0]});
        abs_ang  = ang[AW-1] ? -ang : ang;
        fold_mag = PI_A - abs_ang;
        folded   = ang[AW-1] ? -fold_mag : fold_mag;
        x_sh     = x >>> cnt;
        y_sh     = y >>> cnt;
        if (z[W-1]) begin
            x_nx = x + y_sh;
            y_nx = y - x_sh;
            z_nx = z + atan_tab[cnt];
        end else begin
            x_nx = x - y_sh;
            y_nx = y + x_sh;
            z_nx = z - atan_tab[cnt];
        end
    end

    // Outputs are written on the final rotation edge so valid and the new result appear together in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ang     <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            cnt     <= '0;
            neg_cos <= 1'b0;
            SinQ    <= '0;
            CosQ    <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ang     <= ang_in;
                        neg_cos <= 1'b0;
                        busy    <= 1'b1;
                        state   <= REDUCE;
                    end
                end
                REDUCE: begin
                    if (abs_ang > PI_A) begin
                        ang <= ang[AW-1] ? ang + TWO_PI_A : ang - TWO_PI_A;
                    end else begin
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    if (abs_ang > HALF_PI_A) begin
                        z       <= W'(folded) <<< G;
                        neg_cos <= 1'b1;
                    end else begin
                        z       <= W'(ang) <<< G;
                        neg_cos <= 1'b0;
                    end
                    x     <= X0;
                    y     <= '0;
                    cnt   <= '0;
                    state <= ROTATE;
                end
                ROTATE: begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    if (cnt == LAST_IT) begin
                        SinQ  <= to_sm(y_nx);
                        CosQ  <= to_sm(neg_cos ? -x_nx : x_nx);
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_sincos_cordic.sv
// Self-checking bench for rotor_sincos_cordic: a cycle-level timing model plus floating-point sin/cos
// of the 2*pi-reduced angle, checked every cycle; directed, randomized, reset and sweep stimulus.
module tb_rotor_sincos_cordic;

    localparam int  N        = 24;
    localparam int  ITER     = 14;
    localparam int  PI_Q     = 12868;
    localparam int  TWO_PI_Q = 25736;
    localparam real SCALE    = 4096.0;
    localparam real TOL      = 4.0;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] Qr;
    logic [N-1:0] SinQ;
    logic [N-1:0] CosQ;
    logic         busy;
    logic         valid;

    rotor_sincos_cordic #(.N(N), .Q(12), .ITER(ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .Qr    (Qr),
        .SinQ  (SinQ),
        .CosQ  (CosQ),
        .busy  (busy),
        .valid (valid)
    );

    int  n_cmp    = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  check_en = 1'b0;
    int  m_busy_from;
    int  m_done;
    int  m_free;
    real m_prev_sin;
    real m_prev_cos;
    real m_cur_sin;
    real m_cur_cos;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sm_to_int(input logic [N-1:0] v);
        int m;
        m = int'(v[N-2:0]);
        return v[N-1] ? -m : m;
    endfunction

    function automatic logic [N-1:0] int_to_sm(input int a);
        logic [N-1:0] r;
        r        = '0;
        r[N-1]   = (a < 0);
        r[N-2:0] = (N-1)'(a < 0 ? -a : a);
        return r;
    endfunction

    // Reference: fold the angle into [-pi, pi] with the 2*pi correction rule, then ideal sin/cos
    task automatic model_calc(input logic [N-1:0] q, output int nc, output real s, output real c);
        int a;
        a = int'(q[N-2:0]);
        if (q[N-1]) a = -a;
        nc = 0;
        while (a > PI_Q || a < -PI_Q) begin
            a = (a > 0) ? a - TWO_PI_Q : a + TWO_PI_Q;
            nc++;
        end
        s = $sin(real'(a) / SCALE) * SCALE;
        c = $cos(real'(a) / SCALE) * SCALE;
    endtask

    task automatic model_reset();
        m_prev_sin  = 0.0;
        m_prev_cos  = 0.0;
        m_cur_sin   = 0.0;
        m_cur_cos   = 0.0;
        m_done      = -1;
        m_busy_from = 32'h7fff_ffff;
        m_free      = cyc;
    endtask

    task automatic model_start(input logic [N-1:0] q);
        int  nc;
        real s;
        real c;
        if (cyc >= m_free) begin
            model_calc(q, nc, s, c);
            m_prev_sin  = m_cur_sin;
            m_prev_cos  = m_cur_cos;
            m_cur_sin   = s;
            m_cur_cos   = c;
            m_busy_from = cyc + 1;
            m_done      = cyc + ITER + 3 + nc;
            m_free      = m_done + 1;
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_exact(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d actual=0x%06h required=0x%06h", name, cyc, act, exp);
        end
    endtask

    task automatic check_near(input string name, input real act, input real exp, input real tol);
        real err;
        n_cmp++;
        err = act - exp;
        if (err < 0.0) err = -err;
        if (err > tol) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0.3f required=%0.3f +/-%0.1f", name, act, exp, tol);
        end
    endtask

    task automatic check_sm(input string name, input logic [N-1:0] act, input real exp);
        real err;
        bit  bad;
        n_cmp++;
        err = real'(sm_to_int(act)) - exp;
        if (err < 0.0) err = -err;
        bad = (err > TOL) || (act[N-1] && act[N-2:0] == '0) || $isunknown(act);
`ifdef SINCOS_SAT_EN
        if (act[N-2:0] > (N-1)'(4096)) bad = 1'b1;
`endif
        if (bad) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d actual=0x%06h (%0d) required=%0.2f +/-4 sign-magnitude",
                     name, cyc, act, sm_to_int(act), exp);
        end
    endtask

    task automatic check_output();
        logic exp_valid;
        logic exp_busy;
        exp_valid = (cyc == m_done);
        exp_busy  = (cyc >= m_busy_from) && (cyc < m_done);
        check_bit("valid", valid, exp_valid);
        check_bit("busy", busy, exp_busy);
        check_sm("SinQ", SinQ, (cyc >= m_done) ? m_cur_sin : m_prev_sin);
        check_sm("CosQ", CosQ, (cyc >= m_done) ? m_cur_cos : m_prev_cos);
    endtask

    always @(negedge clk) begin
        if (check_en) check_output();
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [N-1:0] q);
        start = 1'b1;
        Qr    = q;
        model_start(q);
        @(posedge clk);
        #1;
        start = 1'b0;
        Qr    = N'($urandom);
    endtask

    task automatic apply_stimulus(input logic [N-1:0] q);
        int budget;
        budget = 1000;
        while (cyc < m_free && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL idle-wait cyc=%0d actual=timeout required=idle", cyc);
        end
        pulse_start(q);
    endtask

    task automatic pin_model();
        int  nc;
        real s;
        real c;
        model_calc(24'd28672, nc, s, c);
        check_near("model 7.0 corrections", real'(nc), 1.0, 0.0);
        check_near("model 7.0 sin", s, 2691.0, 1.0);
        check_near("model 7.0 cos", c, 3088.0, 1.0);
        model_calc(24'h7FFFFF, nc, s, c);
        check_near("model max corrections", real'(nc), 326.0, 0.0);
        model_calc(24'h800861, nc, s, c);
        check_near("model -0.5236 sin", s, -2048.0, 1.0);
        check_near("model -0.5236 cos", c, 3547.0, 1.0);
        model_calc(24'd6434, nc, s, c);
        check_near("model pi/2 sin", s, 4096.0, 1.0);
        check_near("model pi/2 cos", c, 0.0, 1.0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] q;
        int           extra;

        reset = 1'b1;
        start = 1'b0;
        Qr    = '0;
        model_reset();
        pin_model();

        #1 reset = 1'b0;
        #2;
        check_exact("reset SinQ", SinQ, '0);
        check_exact("reset CosQ", CosQ, '0);
        check_bit("reset busy", busy, 1'b0);
        check_bit("reset valid", valid, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        check_en = 1'b1;

        $display("[TB] directed angles");
        apply_stimulus(24'h000000);
        apply_stimulus(24'd6434);
        apply_stimulus(24'h800861);
        apply_stimulus(24'd28672);
        apply_stimulus(24'h7FFFFF);
        apply_stimulus(24'h800000);
        apply_stimulus(24'hFFFFFF);

        $display("[TB] start re-pulsed while busy and in DONE");
        apply_stimulus(24'd1000);
        idle_cycles(2);
        pulse_start(24'd9000);
        idle_cycles(12);
        pulse_start(24'h801234);
        pulse_start(24'd3000);
        apply_stimulus(24'd12000);

        $display("[TB] reset during ROTATE");
        apply_stimulus(24'd28672);
        apply_stimulus(24'd5000);
        idle_cycles(8);
        #2;
        reset = 1'b0;
        #1;
        check_exact("abort SinQ", SinQ, '0);
        check_exact("abort CosQ", CosQ, '0);
        check_bit("abort busy", busy, 1'b0);
        check_bit("abort valid", valid, 1'b0);
        model_reset();
        idle_cycles(2);
        reset = 1'b1;
        model_reset();
        apply_stimulus(24'h000000);

        $display("[TB] randomized angles and stray starts");
        for (int r = 0; r < 60; r++) begin
            if ($urandom_range(0, 3) == 0) q = N'($urandom);
            else q = int_to_sm((($urandom_range(0, 1) == 1) ? -1 : 1) * int'($urandom_range(0, 40000)));
            apply_stimulus(q);
            extra = int'($urandom_range(0, 2));
            for (int k = 0; k < extra; k++) begin
                idle_cycles(int'($urandom_range(0, 20)));
                pulse_start(N'($urandom));
            end
        end

        $display("[TB] sweep -pi..pi in 64-LSB steps");
        for (int a = -PI_Q; a <= PI_Q; a += 64) begin
            apply_stimulus(int_to_sm(a));
        end

        while (cyc <= m_free + 1) begin
            @(posedge clk);
            #1;
        end
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rotor_sincos_cordic.md
ROTOR_SINCOS_CORDIC -- requirements
Module: rotor_sincos_cordic

Interface
REQ-001 Parameter N, default 24, SHALL set the word width of Qr, SinQ and CosQ.
REQ-002 Parameter Q, default 12, SHALL set the fractional bits; all words are sign-magnitude (bit N-1 is the sign, bits N-2:0 are the magnitude).
REQ-003 Parameter ITER, default 14, SHALL set the number of CORDIC rotation cycles.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: request pulse; Qr is sampled on the same edge.
REQ-007 Port Qr, input, N bits: rotor angle in radians.
REQ-008 Port SinQ, output, N bits: sin(Qr).
REQ-009 Port CosQ, output, N bits: cos(Qr).
REQ-010 Port busy, output, 1 bit: high from the cycle after an accepted start until valid is pulsed.
REQ-011 Port valid, output, 1 bit: single-cycle pulse marking new SinQ/CosQ.

Function
REQ-012 start SHALL be accepted only in IDLE; start while busy SHALL be ignored, with no effect on the run in progress.
REQ-013 FSM states SHALL be IDLE, REDUCE, FOLD, ROTATE and DONE; transitions: IDLE->REDUCE on start; REDUCE->REDUCE while |angle|>pi; REDUCE->FOLD otherwise; FOLD->ROTATE; ROTATE->DONE after ITER cycles; DONE->IDLE.
REQ-014 On accept, Qr SHALL be converted to internal two's complement; 0x800000 (negative zero) SHALL be treated as +0.
REQ-015 REDUCE SHALL add or subtract 2*pi (25736) once per cycle, toward zero, until |angle| <= pi (12868); worst-case count is bounded by 2^(N-1)/25736, and 326 cycles at defaults.
REQ-016 FOLD: if |angle| > pi/2 (6434), the angle SHALL become sign(angle)*(pi - |angle|) and a cos-negate flag SHALL be set; otherwise the flag is cleared.
REQ-017 ROTATE SHALL run circular-mode CORDIC with x0 = K = 2487 (0.60725 scaled), y0 = 0 and a z-residue driven toward 0.
- Iteration i uses shifts of 2^-i and a constant arctan(2^-i) table, i = 0..ITER-1.
- The datapath is at least N+2 bits of two's complement with 4 extra fractional guard bits.
REQ-018 DONE SHALL register SinQ = y and CosQ = x (negated if the flag is set), converted to sign-magnitude.
- A zero magnitude always carries sign 0.
- valid is high for exactly this cycle.
REQ-019 Latency from the start-sampling edge to valid high SHALL be ITER+3 cycles (17 at defaults) plus one cycle per REDUCE correction.
REQ-020 SinQ/CosQ SHALL hold their last result until the next DONE; they never change mid-computation.
REQ-021 Absolute error of each output SHALL be <= 4 LSB (Q12) across all inputs.
REQ-022 A new start in the same cycle as DONE SHALL be ignored; it is accepted from IDLE on the next cycle.

Reset
REQ-023 reset low SHALL force immediately, regardless of clk: state IDLE, SinQ = 0, CosQ = 0, busy = 0, valid = 0, internal x/y/z/counters = 0.
REQ-024 Reset asserted mid-run SHALL abort the run with no valid pulse; the first start after deassertion SHALL be processed normally.

Configuration
REQ-025 Macro SINCOS_SAT_EN defined: output magnitudes SHALL be clamped to 4096 (1.0) in DONE.
REQ-026 Macro SINCOS_SAT_EN undefined: raw CORDIC magnitudes SHALL be output, which may exceed 4096 by the residual gain error; no other behaviour differs.

Verification
REQ-027 Qr=0x000000, start pulse -> valid at cycle 17, SinQ=0x000000 +/-4, CosQ=4096 +/-4, busy high for cycles 1..16.
REQ-028 Qr=6434 (pi/2) -> SinQ=4096 +/-4, CosQ magnitude <= 4; Qr=0x800861 (-0.5236) -> SinQ=0x800800 +/-4 (-0.5), CosQ=3547 +/-4.
REQ-029 Qr=28672 (7.0 rad) -> one REDUCE correction, valid at cycle 18, SinQ=2691 +/-4, CosQ=3088 +/-4; Qr=0x7FFFFF -> completes, with valid at 17 + correction count.
REQ-030 start re-pulsed at cycles 3 and 16 of a run -> both ignored, exactly one valid pulse, outputs match the first Qr.
REQ-031 reset pulsed low during ROTATE -> outputs/busy/valid = 0 asynchronously, no valid pulse; next start with Qr=0 -> normal result at cycle 17.
REQ-032 With SINCOS_SAT_EN, sweep Qr over -pi..pi in 64-LSB steps -> no output magnitude > 4096 and no negative zero; without it, error <= 4 LSB at every point.
